// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage with a valid/ready handshake and a req/ack data-memory port.
// Supports wait states, flush of the in-flight entry, and a bounded-wait timeout with a sticky error flag.
module mem_access_stage #(
  parameter int          DW      = 12,
  parameter int          IW      = 12,
  parameter int          SW      = 4,
  parameter int          FW      = 4,
  parameter logic [SW-1:0] SET_RST = '0,
  parameter int          TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] result_in,
  input  logic [DW-1:0] store_data_in,
  input  logic [IW-1:0] instr_in,
  input  logic [SW-1:0] set_in,
  input  logic [FW-1:0] flags_in,
  input  logic          is_branch_in,
  input  logic          is_load_in,
  input  logic          is_store_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] store_data_out,
  output logic [IW-1:0] instr_out,
  output logic [SW-1:0] set_out,
  output logic [FW-1:0] flags_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  input  logic          err_clr
);

  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

  typedef enum logic [1:0] {EMPTY, ACCESS, FULL} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, result_q, result_d, store_data_q, store_data_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [SW-1:0] set_q, set_d;
  logic [FW-1:0] flags_q, flags_d;
  logic          is_load_q, is_load_d, is_store_q, is_store_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic          accept, timeout_hit;

  assign in_ready = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && !mem_ack
                       && (wait_cnt_q == TMAX_C);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    instr_d      = instr_q;
    set_d        = set_q;
    flags_d      = flags_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    kill_d       = kill_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    case (state_q)
      EMPTY: state_d = EMPTY;
      ACCESS: begin
        // A killed entry still finishes its bus transaction, then vanishes.
        if (mem_ack) begin
          if (is_load_q) result_d = mem_rdata;
          state_d = (kill_q | flush) ? EMPTY : FULL;
          kill_d  = 1'b0;
        end else if (timeout_hit) begin
          state_d = EMPTY;
          kill_d  = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (flush) kill_d = 1'b1;
        end
      end
      FULL: begin
        if (flush || out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    // Accept is only possible from EMPTY or a draining FULL, so it overrides the above.
    if (accept) begin
      pc_d         = is_branch_in ? result_in : pc_in;
      result_d     = result_in;
      store_data_d = store_data_in;
      instr_d      = instr_in;
      set_d        = set_in;
      flags_d      = flags_in;
      is_load_d    = is_load_in;
      is_store_d   = is_store_in;
      kill_d       = 1'b0;
      wait_cnt_d   = '0;
      state_d      = (is_load_in | is_store_in) ? ACCESS : FULL;
    end

    if (err_clr)     err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;

    out_valid_d = (state_d == FULL);
    mem_req_d   = (state_d == ACCESS);
    mem_we_d    = mem_req_d & is_store_d;
    mem_addr_d  = mem_req_d ? result_d : '0;
    mem_wdata_d = mem_we_d ? store_data_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      pc_q         <= '0;
      result_q     <= '0;
      store_data_q <= '0;
      instr_q      <= '0;
      set_q        <= SET_RST;
      flags_q      <= '0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      kill_q       <= 1'b0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      instr_q      <= instr_d;
      set_q        <= set_d;
      flags_q      <= flags_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      kill_q       <= kill_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign pc_out         = pc_q;
  assign result_out     = result_q;
  assign store_data_out = store_data_q;
  assign instr_out      = instr_q;
  assign set_out        = set_q;
  assign flags_out      = flags_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: non-memory ops, branch, load wait states, store stall,
// flush of an in-flight store, timeout with sticky error, and asynchronous reset mid-access.
module tb_mem_access_stage;

  localparam int DW = 12;
  localparam int IW = 12;
  localparam int SW = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] pc_in, result_in, store_data_in;
  logic [IW-1:0] instr_in;
  logic [SW-1:0] set_in;
  logic [FW-1:0] flags_in;
  logic          is_branch_in, is_load_in, is_store_in;
  logic [DW-1:0] pc_out, result_out, store_data_out;
  logic [IW-1:0] instr_out;
  logic [SW-1:0] set_out;
  logic [FW-1:0] flags_out;
  logic          mem_req, mem_we, mem_ack, err, err_clr;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(
    .DW(DW), .IW(IW), .SW(SW), .FW(FW), .SET_RST(4'hA), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .result_in(result_in), .store_data_in(store_data_in),
    .instr_in(instr_in), .set_in(set_in), .flags_in(flags_in),
    .is_branch_in(is_branch_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .result_out(result_out), .store_data_out(store_data_out),
    .instr_out(instr_out), .set_out(set_out), .flags_out(flags_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [DW-1:0] pc, input logic [DW-1:0] res,
                          input logic [DW-1:0] sd, input logic br, input logic ld,
                          input logic st);
    in_valid      = 1'b1;
    pc_in         = pc;
    result_in     = res;
    store_data_in = sd;
    is_branch_in  = br;
    is_load_in    = ld;
    is_store_in   = st;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc_in = '0; result_in = '0; store_data_in = '0; instr_in = '0; set_in = '0; flags_in = '0;
    is_branch_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pc_out", 32'(pc_out), 0);
    chk("rst_set_out", 32'(set_out), 'hA);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    step();

    // Non-memory ops back to back, then a branch
    drive_op('h010, 'h055, 'h000, 1'b0, 1'b0, 1'b0);
    set_in = 4'h3; instr_in = 'h0A5; flags_in = 4'h6;
    step();
    chk("add_out_valid", 32'(out_valid), 1);
    chk("add_pc_out", 32'(pc_out), 'h010);
    chk("add_result_out", 32'(result_out), 'h055);
    chk("add_set_out", 32'(set_out), 'h3);
    chk("add_instr_out", 32'(instr_out), 'h0A5);
    chk("add_flags_out", 32'(flags_out), 'h6);
    drive_op('h014, 'h066, 'h000, 1'b0, 1'b0, 1'b0);
    #1;
    chk("b2b_in_ready", 32'(in_ready), 1);
    step();
    chk("b2b_out_valid", 32'(out_valid), 1);
    chk("b2b_pc_out", 32'(pc_out), 'h014);
    chk("b2b_result_out", 32'(result_out), 'h066);
    drive_op('h020, 'h3A0, 'h000, 1'b1, 1'b0, 1'b0);
    step();
    chk("br_pc_out", 32'(pc_out), 'h3A0);
    in_valid = 1'b0; is_branch_in = 1'b0;
    step();
    chk("drain_out_valid", 32'(out_valid), 0);

    // Load with two wait states
    drive_op('h030, 'h123, 'h000, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("ld_c1_req", 32'(mem_req), 1);
    chk("ld_c1_addr", 32'(mem_addr), 'h123);
    chk("ld_c1_we", 32'(mem_we), 0);
    chk("ld_c1_in_ready", 32'(in_ready), 0);
    step();
    chk("ld_c2_req", 32'(mem_req), 1);
    chk("ld_c2_addr", 32'(mem_addr), 'h123);
    chk("ld_c2_out_valid", 32'(out_valid), 0);
    step();
    mem_ack = 1'b1; mem_rdata = 'hBEE;
    #1;
    chk("ld_c3_addr", 32'(mem_addr), 'h123);
    chk("ld_c3_in_ready", 32'(in_ready), 0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("ld_done_req", 32'(mem_req), 0);
    chk("ld_done_out_valid", 32'(out_valid), 1);
    chk("ld_done_result", 32'(result_out), 'hBEE);
    step();
    chk("ld_drain", 32'(out_valid), 0);

    // Store, ack in first cycle, downstream stalled for 4 cycles
    out_ready = 1'b0;
    drive_op('h300, 'h200, 'h7E1, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0; is_store_in = 1'b0; mem_ack = 1'b1;
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_wdata", 32'(mem_wdata), 'h7E1);
    chk("st_addr", 32'(mem_addr), 'h200);
    step();
    mem_ack = 1'b0;
    drive_op('h111, 'h222, 'h000, 1'b0, 1'b0, 1'b0);
    chk("st_after_req", 32'(mem_req), 0);
    chk("st_after_we", 32'(mem_we), 0);
    chk("st_after_wdata", 32'(mem_wdata), 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_stall_valid", 32'(out_valid), 1);
      chk("st_stall_pc", 32'(pc_out), 'h300);
      chk("st_stall_result", 32'(result_out), 'h200);
      chk("st_stall_sdata", 32'(store_data_out), 'h7E1);
      chk("st_stall_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("st_release_in_ready", 32'(in_ready), 1);
    step();
    chk("st_next_valid", 32'(out_valid), 1);
    chk("st_next_pc", 32'(pc_out), 'h111);
    in_valid = 1'b0;
    step();

    // Flush while a store is in flight; ack arrives two cycles later
    drive_op('h040, 'h0AA, 'h555, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0; is_store_in = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_req_held", 32'(mem_req), 1);
    chk("fl_we_held", 32'(mem_we), 1);
    step();
    mem_ack = 1'b1;
    chk("fl_req_ack_cycle", 32'(mem_req), 1);
    chk("fl_no_valid", 32'(out_valid), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("fl_after_req", 32'(mem_req), 0);
    chk("fl_after_valid", 32'(out_valid), 0);
    chk("fl_after_in_ready", 32'(in_ready), 1);
    chk("fl_after_err", 32'(err), 0);
    step();
    chk("fl_still_no_valid", 32'(out_valid), 0);

    // Timeout with no ack
    drive_op('h050, 'h0F0, 'h000, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0; is_load_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 32'(mem_req), 1);
      step();
    end
    chk("to_req_low", 32'(mem_req), 0);
    chk("to_err_set", 32'(err), 1);
    chk("to_no_valid", 32'(out_valid), 0);
    step();
    chk("to_err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err), 0);

    // Flush of a stalled FULL entry
    out_ready = 1'b0;
    drive_op('h060, 'h061, 'h000, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ffull_valid", 32'(out_valid), 1);
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    chk("ffull_flushed", 32'(out_valid), 0);

    // Asynchronous reset in the middle of an access
    drive_op('h070, 'h071, 'h000, 1'b0, 1'b1, 1'b0);
    set_in = 4'h5;
    step();
    in_valid = 1'b0; is_load_in = 1'b0;
    chk("arst_req_before", 32'(mem_req), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_dropped", 32'(mem_req), 0);
    chk("arst_pc_out", 32'(pc_out), 0);
    chk("arst_set_out", 32'(set_out), 'hA);
    step();
    rst = 1'b0;
    step();
    chk("arst_in_ready", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
